// File: rtl/pb_stream_merge_if.sv
// Bus bundle for pb_stream_merge: upstream channel handshakes plus the
// drain-side FIFO interface and status.
// slave  = the merge block's view, master = the environment's view.
interface pb_stream_merge_if #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 24,
    parameter int DEPTH  = 200,
    parameter int CNT_W  = 19
);
    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH*WIDTH-1:0]   ch_data;
    logic [NUM_CH-1:0]         ch_stall;
    logic                      pb_re;
    logic [WIDTH-1:0]          pb_data;
    logic                      pb_empty;
    logic                      pb_full;
    logic [$clog2(DEPTH+1)-1:0] num_in_fifo;
    logic [CNT_W-1:0]          pix_cnt;
    logic                      rendering_done;
    logic                      underflow_err;

    modport slave (
        input  ch_valid, ch_data, pb_re,
        output ch_stall, pb_data, pb_empty, pb_full, num_in_fifo,
               pix_cnt, rendering_done, underflow_err
    );

    modport master (
        output ch_valid, ch_data, pb_re,
        input  ch_stall, pb_data, pb_empty, pb_full, num_in_fifo,
               pix_cnt, rendering_done, underflow_err
    );
endinterface

// File: rtl/pb_stream_merge.sv
// Pixel-buffer front end: round-robin merge of NUM_CH valid/stall result
// streams into one first-word-fall-through FIFO, with a per-frame count of
// drained pixels and a one-cycle rendering_done pulse at frame end.
// Arbitration depends only on registered state and ch_valid, so pb_re
// never reaches ch_stall combinationally (a full FIFO stalls everyone even
// if a read happens in the same cycle).
module pb_stream_merge #(
    parameter int NUM_CH       = 3,
    parameter int WIDTH        = 24,
    parameter int DEPTH        = 200,
    parameter int FRAME_PIXELS = 307200,
    parameter int CNT_W        = 19
) (
    input  logic clk,
    input  logic rst,
    pb_stream_merge_if.slave bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W:0]   NUM_CH_X  = (PTR_W + 1)'(NUM_CH);
    localparam logic [PTR_W-1:0] LAST_CH   = PTR_W'(NUM_CH - 1);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_X   = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(FRAME_PIXELS - 1);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_vld;
    logic [PTR_W:0]   cand;
    logic [NUM_CH-1:0] stall;
    logic [WIDTH-1:0] wr_data;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    logic [CNT_W-1:0] pix_cnt;
    logic             rendering_done;
    logic             underflow_err;

    assign full  = (occ == DEPTH_X);
    assign empty = (occ == '0);

    // Round-robin search starting at rr_ptr; the first valid channel wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (cand >= NUM_CH_X) begin
                cand = cand - NUM_CH_X;
            end
            if (!grant_vld && bus.ch_valid[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (full) begin
            grant_vld = 1'b0;
        end
    end

    // Only the granted channel is released; everyone else holds
    always_comb begin
        stall = '1;
        if (grant_vld) begin
            stall[grant_idx] = 1'b0;
        end
    end

    assign wr_data = bus.ch_data[int'(grant_idx) * WIDTH +: WIDTH];
    assign wr_en   = grant_vld;
    assign rd_en   = bus.pb_re && !empty;

    // Pointer moves past the winner so it has lowest priority next time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Circular-buffer pointers and occupancy (DEPTH need not be a power of 2)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                occ <= occ + 1'b1;
            end else if (rd_en && !wr_en) begin
                occ <= occ - 1'b1;
            end
        end
    end

    // Frame pixel counter, end-of-frame pulse and sticky underflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt        <= '0;
            rendering_done <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            rendering_done <= 1'b0;
            if (rd_en) begin
                if (pix_cnt == LAST_PIX) begin
                    pix_cnt        <= '0;
                    rendering_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
            if (bus.pb_re && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    assign bus.ch_stall       = stall;
    assign bus.pb_data        = mem[rd_ptr];
    assign bus.pb_empty       = empty;
    assign bus.pb_full        = full;
    assign bus.num_in_fifo    = occ;
    assign bus.pix_cnt        = pix_cnt;
    assign bus.rendering_done = rendering_done;
    assign bus.underflow_err  = underflow_err;
endmodule

// File: doc/pb_stream_merge.md
Name: pb_stream_merge

Overview:
- Parametrised pixel-buffer front end for the ray pipeline.
- Merges NUM_CH valid/stall result streams (e.g. traversal, shadow, shader exits) into one FIFO with fair round-robin arbitration.
- Drained by frame_buffer_handler via pb_re.
- Counts drained pixels per frame and pulses rendering_done to camera_controller at frame end.

Parameters:
- NUM_CH, 3, number of upstream channels (>=1).
- WIDTH, 24, bits per pixel_buffer_entry_t.
- DEPTH, 200, FIFO entries (>=2, need not be a power of 2).
- FRAME_PIXELS, 307200, pixels per frame.
- CNT_W, 19, pixel counter width; must hold FRAME_PIXELS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ch_valid  in  NUM_CH  channel i presents data.
- ch_data  in  NUM_CH*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
- ch_stall  out  NUM_CH  channel i must hold its data this cycle.
- pb_re  in  1  consumer read strobe.
- pb_data  out  WIDTH  FIFO head (first-word fall-through).
- pb_empty  out  1  FIFO empty.
- pb_full  out  1  FIFO full.
- num_in_fifo  out  $clog2(DEPTH+1)  occupancy.
- pix_cnt  out  CNT_W  pixels read in the current frame.
- rendering_done  out  1  one-cycle frame-complete pulse.
- underflow_err  out  1  sticky: pb_re while empty.

Behaviour:
- Reset:
  - Asynchronous on rst high.
  - FIFO empty, occupancy 0, pb_empty=1, pb_full=0.
  - RR pointer=0, pix_cnt=0, rendering_done=0, underflow_err=0.
  - pb_data don't-care while empty.
  - Reset mid-frame discards all FIFO contents and the count.
- Transfer rule: a beat on channel i transfers when ch_valid[i] && !ch_stall[i]. Upstream holds ch_data stable while stalled.
- Arbitration (combinational from registered state):
  - If pb_full: all ch_stall=1, no grant.
  - Else grant the first valid channel searching ptr, ptr+1, ... mod NUM_CH.
  - Granted channel: ch_stall=0. Every other channel: ch_stall=1.
  - Non-valid channels may see any stall value.
  - At most one write per cycle.
  - After a grant to channel g, ptr <= (g+1) mod NUM_CH. With no grant, ptr holds.
- FIFO:
  - Circular buffer of DEPTH entries; wr/rd pointers wrap at DEPTH-1 -> 0.
  - Write takes effect on the clock edge. Written data is visible at pb_data the next cycle if the FIFO was empty (1-cycle write-to-read latency).
  - pb_full is based on registered occupancy only; there is no write-through on a simultaneous read when full.
  - Simultaneous read and write when not full and not empty: occupancy unchanged.
  - pb_full = (occupancy==DEPTH); pb_empty = (occupancy==0).
- Read:
  - Accepted when pb_re && !pb_empty: head advances, pix_cnt increments.
  - pb_re while empty: ignored, no pointer/count change, underflow_err <= 1 (sticky until rst).
- Frame counting:
  - On an accepted read with pix_cnt==FRAME_PIXELS-1: pix_cnt <= 0 and rendering_done <= 1 for exactly the next cycle.
  - Otherwise rendering_done <= 0.
  - Back-to-back frames give one pulse per FRAME_PIXELS reads.
- No combinational path from pb_re to ch_stall.

Test Plan:
- Reset: assert rst async mid-clock with 5 entries queued -> immediately pb_empty=1, num_in_fifo=0, pix_cnt=0, rendering_done=0, ch_stall=0 for valid ch0 the next cycle.
- Round-robin fairness: NUM_CH=3, all valid continuously, pb_re=1 -> writes in order ch0,ch1,ch2,ch0,...; each channel gets exactly 10 grants in 30 cycles.
- Single requester: only ch2 valid from ptr=0 -> ch2 granted every cycle, ptr stays at 0 after each grant; ch0/ch1 become valid later -> ch0 granted next.
- Full: DEPTH=4, pb_re=0, ch0 writes 0x11..0x44 -> pb_full=1, ch_stall[0]=1 with ch_valid[0]=1, data held. One read -> next cycle pb_full=0, 0x55 accepted, read order 0x11,0x22,0x33,0x44,0x55.
- Frame: FRAME_PIXELS=8, 20 reads -> rendering_done high exactly on the cycles after the 8th and 16th reads; pix_cnt=4 at the end.
- Underflow: pb_re=1 while empty -> underflow_err=1, pix_cnt unchanged, remains 1 after subsequent normal traffic until rst.
